// File: rtl/dmem_refill_ctrl.sv
// Data-memory miss/refill controller: stalls on a load miss and refills the line byte by byte.
// Latency: stall lasts LINE_BYTES+3 cycles with zero-wait grant and back-to-back beats.
// Backpressure: waits in REQ until mem_gnt; FILL holds on mem_rvalid gaps, one extra stall cycle each.
module dmem_refill_ctrl #(
    parameter int LINE_BYTES = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p3_mem_valid,
    input  logic [31:0]       p3_mem_address,
    input  logic              hit,
    output logic              stall,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    output logic              fill_we,
    output logic [31:0]       fill_addr,
    output logic [7:0]        fill_data,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int          BW        = $clog2(LINE_BYTES);
    localparam logic [31:0] ADDR_MASK = 32'(LINE_BYTES - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BYTES - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic [31:0]   line_base;
    logic          miss;

    assign miss = (state == IDLE) & p3_mem_valid & ~hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            line_base  <= '0;
            miss_count <= '0;
            mem_req    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state     <= REQ;
                        line_base <= p3_mem_address & ~ADDR_MASK;
                        beat_cnt  <= '0;
                        mem_req   <= 1'b1;
                        if (miss_count != '1)
                            miss_count <= miss_count + CNT_W'(1);
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state   <= FILL;
                        mem_req <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (beat_cnt == LAST_BEAT)
                            state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The request address is the latched line base; it cannot move while REQ waits for grant.
    assign mem_addr  = line_base;
    assign stall     = miss | (state != IDLE);
    assign fill_we   = (state == FILL) & mem_rvalid;
    assign fill_addr = fill_we ? (line_base + 32'(beat_cnt)) : 32'h0;
    assign fill_data = fill_we ? mem_rdata : 8'h0;

endmodule

// File: tb/tb_dmem_refill_ctrl.sv
// Directed bench for dmem_refill_ctrl; a behavioural backing memory answers the refill requests.
module tb_dmem_refill_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        p3_mem_valid;
    logic [31:0] p3_mem_address;
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        fill_we;
    logic [31:0] fill_addr;
    logic [7:0]  fill_data;
    logic [15:0] miss_count;

    logic        sat_stall, sat_mem_req, sat_fill_we;
    logic [31:0] sat_mem_addr, sat_fill_addr;
    logic [7:0]  sat_fill_data;
    logic [1:0]  sat_miss_count;

    int checks = 0;
    int failures = 0;

    // observations recorded by run_refill
    int          stall_cycles, nwr, req_cycles;
    bit          req_bad, wr_outside, zero_bad, timeout;
    logic [31:0] wr_a [0:7];
    logic [7:0]  wr_d [0:7];

    always #5 clk = ~clk;

    dmem_refill_ctrl #(.LINE_BYTES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .p3_mem_valid(p3_mem_valid), .p3_mem_address(p3_mem_address),
        .hit(hit), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .fill_we(fill_we), .fill_addr(fill_addr),
        .fill_data(fill_data), .miss_count(miss_count)
    );

    dmem_refill_ctrl #(.LINE_BYTES(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .p3_mem_valid(p3_mem_valid), .p3_mem_address(p3_mem_address),
        .hit(hit), .stall(sat_stall), .mem_req(sat_mem_req), .mem_addr(sat_mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .fill_we(sat_fill_we), .fill_addr(sat_fill_addr),
        .fill_data(sat_fill_data), .miss_count(sat_miss_count)
    );

    // One miss on address a, served by a backing memory with gnt_dly wait cycles and a gap_len
    // rvalid gap after beat 1. spurious pulses rvalid before grant and moves the address mid-FILL.
    // b2b returns right after the DONE cycle so the caller can miss again in the next cycle.
    task automatic run_refill(input logic [31:0] a, input int gnt_dly, input int gap_len,
                              input bit spurious, input bit b2b, input logic [7:0] d0);
        logic [31:0] base;
        int  wait_cnt, beats, gap_left;
        bit  granted, in_done;
        base = a & ~32'h3;
        stall_cycles = 0; nwr = 0; req_cycles = 0;
        req_bad = 0; wr_outside = 0; zero_bad = 0; timeout = 1;
        wait_cnt = 0; beats = 0; gap_left = gap_len; granted = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            in_done = granted && (beats == 4);
            p3_mem_valid = 1'b1;
            p3_mem_address = a;
            hit = (beats == 4);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
            if (mem_req) begin
                if (wait_cnt == gnt_dly) mem_gnt = 1'b1;
                else wait_cnt++;
            end
            if (granted && beats < 4) begin
                if (gap_left > 0 && beats == 2) gap_left--;
                else begin
                    mem_rvalid = 1'b1;
                    mem_rdata = d0 + 8'(beats);
                end
                if (spurious && beats >= 2) p3_mem_address = 32'hFFFF_FF00;
            end else if (spurious && !granted) begin
                mem_rvalid = 1'b1;
                mem_rdata = 8'hEE;
            end
            #1;
            if (stall) stall_cycles++;
            if (mem_req) begin
                req_cycles++;
                if (mem_addr !== base) req_bad = 1;
            end
            if (fill_we) begin
                if (!granted || !mem_rvalid) wr_outside = 1;
                if (nwr < 8) begin
                    wr_a[nwr] = fill_addr;
                    wr_d[nwr] = fill_data;
                end
                nwr++;
            end else if (fill_addr !== 32'h0 || fill_data !== 8'h0) begin
                zero_bad = 1;
            end
            if (mem_rvalid && granted) beats++;
            if (mem_gnt) granted = 1;
            if ((in_done && b2b) || (!stall && k > 0)) begin
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0; p3_mem_valid = 1'b0; hit = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p3_mem_valid = 1'($urandom); p3_mem_address = $urandom; hit = 1'b1;
            mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = 8'($urandom);
            #7;
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
            checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
            checks++; if (fill_we !== 1'b0) begin failures++; $display("FAIL reset_fill_we got=%b exp=0", fill_we); end
            checks++; if (miss_count !== 16'd0) begin failures++; $display("FAIL reset_miss_count got=%0d exp=0", miss_count); end
            checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        end
        @(negedge clk);
        reset = 1'b1; p3_mem_valid = 1'b1; hit = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL release_stall got=%b exp=0", stall); end
        end
    endtask

    task automatic test_basic_miss();
        run_refill(32'h0000_0013, 0, 0, 0, 0, 8'hA0);
        checks++; if (timeout) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++; if (stall_cycles != 7) begin failures++; $display("FAIL basic_stall_cycles got=%0d exp=7", stall_cycles); end
        checks++; if (nwr != 4) begin failures++; $display("FAIL basic_writes got=%0d exp=4", nwr); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_a[i] !== 32'h10 + 32'(i)) begin failures++; $display("FAIL basic_fill_addr[%0d] got=%h exp=%h", i, wr_a[i], 32'h10 + 32'(i)); end
            checks++; if (wr_d[i] !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL basic_fill_data[%0d] got=%h exp=%h", i, wr_d[i], 8'hA0 + 8'(i)); end
        end
        checks++; if (req_cycles != 1 || req_bad) begin failures++; $display("FAIL basic_req got=%0d/%0b exp=1/0", req_cycles, req_bad); end
        checks++; if (wr_outside || zero_bad) begin failures++; $display("FAIL basic_write_qual got=%0b/%0b exp=0/0", wr_outside, zero_bad); end
        checks++; if (miss_count !== 16'd1) begin failures++; $display("FAIL basic_miss_count got=%0d exp=1", miss_count); end
    endtask

    task automatic test_wait_states();
        run_refill(32'h0000_2467, 3, 2, 0, 0, 8'h50);
        checks++; if (timeout) begin failures++; $display("FAIL wait_timeout got=1 exp=0"); end
        checks++; if (stall_cycles != 12) begin failures++; $display("FAIL wait_stall_cycles got=%0d exp=12", stall_cycles); end
        checks++; if (nwr != 4) begin failures++; $display("FAIL wait_writes got=%0d exp=4", nwr); end
        checks++; if (wr_a[3] !== 32'h2467 || wr_d[3] !== 8'h53) begin failures++; $display("FAIL wait_last_write got=%h/%h exp=00002467/53", wr_a[3], wr_d[3]); end
        checks++; if (req_cycles != 4) begin failures++; $display("FAIL wait_req_cycles got=%0d exp=4", req_cycles); end
        checks++; if (req_bad) begin failures++; $display("FAIL wait_mem_addr_stable got=1 exp=0"); end
        checks++; if (miss_count !== 16'd2) begin failures++; $display("FAIL wait_miss_count got=%0d exp=2", miss_count); end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        p3_mem_valid = 1'b0; hit = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 8'h77;
        #1;
        checks++; if (fill_we !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL idle_spurious got=%b/%b exp=0/0", fill_we, stall); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL idle_gnt_ignored got=%b/%b exp=0/0", mem_req, stall); end
        run_refill(32'h8000_0FFE, 0, 0, 1, 0, 8'hC0);
        checks++; if (timeout || stall_cycles != 7) begin failures++; $display("FAIL spur_stall_cycles got=%0d exp=7", stall_cycles); end
        checks++; if (nwr != 4 || wr_outside) begin failures++; $display("FAIL spur_writes got=%0d/%0b exp=4/0", nwr, wr_outside); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_a[i] !== 32'h8000_0FFC + 32'(i)) begin failures++; $display("FAIL spur_fill_addr[%0d] got=%h exp=%h", i, wr_a[i], 32'h8000_0FFC + 32'(i)); end
        end
        checks++; if (miss_count !== 16'd3) begin failures++; $display("FAIL spur_miss_count got=%0d exp=3", miss_count); end
    endtask

    task automatic test_back_to_back();
        run_refill(32'hFFFF_FFFE, 0, 0, 0, 1, 8'h10);
        checks++; if (timeout || stall_cycles != 7) begin failures++; $display("FAIL b2b_first_stall got=%0d exp=7", stall_cycles); end
        checks++; if (wr_a[3] !== 32'hFFFF_FFFF || wr_d[3] !== 8'h13) begin failures++; $display("FAIL top_line_last got=%h/%h exp=ffffffff/13", wr_a[3], wr_d[3]); end
        run_refill(32'h0000_0041, 0, 0, 0, 0, 8'h20);
        checks++; if (timeout || stall_cycles != 7) begin failures++; $display("FAIL b2b_second_stall got=%0d exp=7", stall_cycles); end
        checks++; if (wr_a[0] !== 32'h40 || wr_d[0] !== 8'h20) begin failures++; $display("FAIL b2b_first_write got=%h/%h exp=00000040/20", wr_a[0], wr_d[0]); end
        checks++; if (miss_count !== 16'd5) begin failures++; $display("FAIL b2b_miss_count got=%0d exp=5", miss_count); end
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        p3_mem_valid = 1'b1; p3_mem_address = 32'h100; hit = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk); mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 8'h31;
        #1;
        checks++; if (fill_we !== 1'b1 || fill_addr !== 32'h100) begin failures++; $display("FAIL midfill_beat0 got=%b/%h exp=1/00000100", fill_we, fill_addr); end
        @(negedge clk); mem_rdata = 8'h32;
        @(negedge clk); mem_rdata = 8'h33;
        #1;
        reset = 1'b0; p3_mem_valid = 1'b0;
        #1;
        checks++; if (fill_we !== 1'b0 || fill_addr !== 32'h0) begin failures++; $display("FAIL midfill_rst_fill got=%b/%h exp=0/00000000", fill_we, fill_addr); end
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL midfill_rst_req got=%b/%b exp=0/0", mem_req, stall); end
        checks++; if (miss_count !== 16'd0) begin failures++; $display("FAIL midfill_rst_count got=%0d exp=0", miss_count); end
        @(negedge clk);
        reset = 1'b1; mem_rvalid = 1'b0;
        run_refill(32'h0000_0106, 0, 0, 0, 0, 8'h90);
        checks++; if (timeout || nwr != 4) begin failures++; $display("FAIL restart_writes got=%0d exp=4", nwr); end
        checks++; if (wr_a[0] !== 32'h104 || wr_d[0] !== 8'h90) begin failures++; $display("FAIL restart_beat0 got=%h/%h exp=00000104/90", wr_a[0], wr_d[0]); end
        checks++; if (miss_count !== 16'd1) begin failures++; $display("FAIL restart_count got=%0d exp=1", miss_count); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat [0:4];
        exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            run_refill(32'h200 + 32'(i * 16), 0, 0, 0, 0, 8'(i * 4));
            checks++; if (sat_miss_count !== exp_sat[i]) begin failures++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, sat_miss_count, exp_sat[i]); end
            checks++; if (miss_count !== 16'(i + 1)) begin failures++; $display("FAIL wide_count[%0d] got=%0d exp=%0d", i, miss_count, i + 1); end
        end
    endtask

    initial begin
        reset = 1'b0; p3_mem_valid = 1'b0; p3_mem_address = 32'h0; hit = 1'b1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h0;
        test_reset();
        test_basic_miss();
        test_wait_states();
        test_spurious();
        test_back_to_back();
        test_reset_mid_fill();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_refill_ctrl.md
# dmem_refill_ctrl

Miss/refill controller for the byte-wide data memory in the MEM stage. It watches the p3 load address and the data memory's `hit` flag. On a miss it stalls the pipeline and fetches the whole line from backing memory over a request/grant plus read-valid handshake. It writes each returned byte into the data memory, then releases the stall so the access replays as a hit. It also keeps a saturating miss counter for performance monitoring.

## Interface
Parameters:
- `LINE_BYTES`, default 4: bytes per line. Must be a power of 2 and ≥2.
- `CNT_W`, default 16: width of the miss counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `p3_mem_valid`  in  1  MEM-stage load present this cycle.
- `p3_mem_address`  in  32  byte address of the load.
- `hit`  in  1  data memory hit for `p3_mem_address` (combinational from dataMem).
- `stall`  out  1  freezes pipeline registers p1–p4 and the PC.
- `mem_req`  out  1  line request to backing memory.
- `mem_addr`  out  32  line-aligned request address.
- `mem_gnt`  in  1  backing memory accepted the request.
- `mem_rvalid`  in  1  a refill byte is present on `mem_rdata`.
- `mem_rdata`  in  8  refill byte.
- `fill_we`  out  1  write strobe into the data memory.
- `fill_addr`  out  32  byte address being filled.
- `fill_data`  out  8  byte being filled.
- `miss_count`  out  CNT_W  number of misses, saturating.

## Operation
- There are four states: IDLE, REQ, FILL and DONE.
- A miss is `p3_mem_valid & ~hit` while in IDLE. If `p3_mem_valid` is 0, no miss occurs regardless of `hit`.
- IDLE → REQ on a miss. At the same edge:
  - latch `line_base = p3_mem_address` with the low log2(LINE_BYTES) bits cleared;
  - clear `beat_cnt`;
  - increment `miss_count` unless it is at all-ones.
- REQ:
  - `mem_req=1` and `mem_addr=line_base`, held stable until grant.
  - → FILL at the first edge where `mem_gnt=1`.
  - `mem_rvalid` is ignored.
- FILL: each cycle with `mem_rvalid=1`:
  - drive `fill_we=1`, `fill_addr=line_base+beat_cnt` and `fill_data=mem_rdata`, all combinational in the same cycle;
  - increment `beat_cnt` at the edge.
  - When that beat is number LINE_BYTES-1, go → DONE.
  - Cycles with `mem_rvalid=0` hold state and produce no write.
- DONE: a single cycle with no write and no request, then → IDLE. In IDLE the access replays against the now-filled line.
- Outputs per state:
  - `stall = (IDLE & miss) | REQ | FILL | DONE`.
  - `mem_req` is 1 only in REQ.
  - `fill_we` is 1 only in FILL with `mem_rvalid`.
  - `fill_addr` and `fill_data` are 0 whenever `fill_we=0`.
- Changes to `p3_mem_address` and `hit` outside IDLE are ignored. The address is frozen by `stall` anyway; the block does not rely on that.
- `mem_rvalid` or `mem_gnt` arriving outside REQ/FILL is ignored.
- `beat_cnt` is log2(LINE_BYTES) bits wide and does not wrap within a line. Address arithmetic is a 32-bit unsigned add; a line at the top of memory must not wrap, because `line_base` is aligned.

## Timing
- Reset (`reset=0`, asynchronous), all outputs take these values immediately:
  - state=IDLE, `beat_cnt=0`, `line_base=0`, `miss_count=0`;
  - `stall=0` (apart from the combinational IDLE-miss term), `mem_req=0`, `mem_addr=0`, `fill_we=0`.
- Reset during REQ or FILL abandons the refill. A partially written line is not rolled back; the data memory's valid bit handling is outside this block.
- Miss in cycle N with zero-wait grant and back-to-back beats:
  - N: IDLE, stall=1;
  - N+1: REQ, grant;
  - N+2 … N+1+LINE_BYTES: FILL;
  - N+2+LINE_BYTES: DONE;
  - N+3+LINE_BYTES: IDLE with hit, stall=0.
  - Stall therefore lasts LINE_BYTES+3 cycles in total (7 for the default).
- Each cycle of grant delay or `mem_rvalid` gap adds exactly one stall cycle.
- Back-to-back misses: a new miss can be detected in the first IDLE cycle after DONE. There is no dead cycle beyond DONE.

## Test plan
- Reset values: hold `reset=0` with random inputs → `stall=0`, `mem_req=0`, `fill_we=0`, `miss_count=0`. Release reset with `p3_mem_valid=1`, `hit=1` → `stall` stays 0.
- Basic miss: address 0x0000_0013, `hit=0`, grant immediately, beats 0xA0–0xA3 back-to-back → `mem_addr=0x10`; `fill_addr` 0x10–0x13 with `fill_data` A0–A3; `stall` high exactly 7 cycles; `miss_count=1`.
- Wait states: grant 3 cycles late, then a 2-cycle gap after beat 1 → stall high 12 cycles, still exactly 4 writes, `mem_req` and `mem_addr` stable until grant.
- Spurious inputs: `mem_rvalid` pulsed in IDLE and REQ, and `p3_mem_address` changed mid-FILL → no writes outside FILL, fill addresses still based on the latched line.
- Reset mid-FILL after 2 beats → immediately IDLE, `fill_we=0`, `mem_req=0`, `miss_count=0`. The next miss restarts at beat 0.
- Counter saturation: CNT_W=2, 5 consecutive misses → `miss_count` reads 1, 2, 3, 3, 3.
